mem_access_arbiter: RTL
=======================

# mem_access_arbiter

Two-requester arbiter and access sequencer for the 8x8-bit memory array. It accepts independent read/write requests from ports A and B and grants them round-robin. It drives the memory's select/operation/address/data strobes for exactly one transaction at a time and returns a one-cycle acknowledge, with read data, to the winning requester. It sits between the client logic and the memory control FSM, and is the only block allowed to drive the memory's select and operation inputs.

## Interface
Parameters:
- DATA_W, 8: memory word width.
- ADDR_W, 3: address width (8 words).
- READ_LAT, 1: cycles from memory select to valid i_memRdata; legal range 1..4.

Ports:
- i_clock  in  1  single clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_reqA / i_reqB  in  1  request; level, held until matching ack.
- i_weA / i_weB  in  1  1 = write, 0 = read.
- i_addrA / i_addrB  in  ADDR_W  word address.
- i_wdataA / i_wdataB  in  DATA_W  write data.
- o_ackA / o_ackB  out  1  one-cycle completion pulse.
- o_rdata  out  DATA_W  read data; valid only in an ack cycle of a read.
- o_busy  out  1  high in every state except IDLE.
- o_memSelect  out  1  memory chip select, active high.
- o_memOperation  out  1  1 = write, 0 = read.
- o_memAddr  out  ADDR_W  memory address.
- o_memWdata  out  DATA_W  memory write data.
- i_memRdata  in  DATA_W  memory read data.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any request is high, pick a winner and latch its we, addr and wdata into internal registers. Record the winner id, then go to ISSUE. If no request is high, stay in IDLE.
- Arbitration: 1-bit priority pointer, reset value A.
  - Only one requester high: that requester wins.
  - Both high: the pointer's requester wins.
  - After every grant, the pointer moves to the loser, so contention alternates A, B, A, B.
- ISSUE (one cycle): o_memSelect=1; o_memOperation, o_memAddr and o_memWdata come from the latched registers. Write goes to ACK; read goes to WAIT.
- WAIT: lasts READ_LAT cycles, counted by a down-counter. On the last WAIT cycle, capture i_memRdata into the o_rdata register, then go to ACK. o_memSelect=0 during WAIT.
- ACK (one cycle): pulse the winner's ack and hold o_rdata, then go to IDLE.
- The latched transaction is immutable once granted. Changes to requester inputs, or dropping req, after grant do not affect the transaction; ack still pulses.
- Write data is not reflected on o_rdata; o_rdata keeps its last value.
- Address and data are passed through unmodified; no arithmetic beyond the WAIT counter.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, pointer=A.
  - o_ackA=o_ackB=0, o_busy=0.
  - o_memSelect=0, o_memOperation=0, o_memAddr=0, o_memWdata=0, o_rdata=0.
- Reset mid-transaction aborts immediately: no ack is issued, and o_memSelect drops asynchronously.
- Latency is counted with req first sampled high in IDLE at edge 0:
  - Write: ISSUE in cycle 1, ack in cycle 2.
  - Read: ISSUE in cycle 1, WAIT in cycles 2..1+READ_LAT, ack with o_rdata in cycle 2+READ_LAT.
- Throughput: IDLE follows every ACK, so back-to-back writes complete every 3 cycles and reads every 3+READ_LAT cycles.
- A requester that keeps req high after its ack is a new request. It competes at the next IDLE, where the pointer now favours the other port.
- All memory-side outputs are registered. o_memSelect is high for exactly one cycle per transaction.

## Structure
- mem_ctrl_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, ACK);
  - OP_READ=0 and OP_WRITE=1;
  - REQ_A=0 and REQ_B=1.
- MemoryFSM uses the same package for operation encoding.
- Sub-module rr_arbiter2 is combinational: inputs are the two requests and the pointer; outputs are a grant vector and the next pointer. The pointer register stays in mem_access_arbiter.

## Test plan
- Reset then idle:
  - Stimulus: reset, then reqA=reqB=0 for 10 cycles.
  - Required: o_busy=0, o_memSelect never 1, no acks.
- Single write then read, READ_LAT=1:
  - Stimulus: A writes 0xA5 to addr 3, then A reads addr 3.
  - Required: write ack in cycle 2 with memSelect=1 and operation=1 in cycle 1. Read ack in cycle 3 with o_rdata=0xA5.
- Contention:
  - Stimulus: reqA and reqB held high for four transactions.
  - Required: grants go A, B, A, B, and each ack pulses exactly once per grant.
- Input change after grant:
  - Stimulus: B requests a write of 0x3C to addr 7, then changes wdata to 0xFF in the ISSUE cycle.
  - Required: memory sees 0x3C at addr 7.
- Reset mid-read, READ_LAT=4:
  - Stimulus: assert i_reset during the second WAIT cycle.
  - Required: state=IDLE, no ack, all outputs at reset values.
- Sweep READ_LAT from 1 to 4:
  - Required: read ack arrives exactly at cycle 2+READ_LAT.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state, operation and requester encodings for the memory controller blocks
package mem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
   localparam logic OP_READ = 1'b0;
   localparam logic OP_WRITE = 1'b1;
   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant with next-pointer computation
module rr_arbiter2
   import mem_ctrl_pkg::*;
(
   input  logic       req_a,
   input  logic       req_b,
   input  logic       ptr,
   output logic [1:0] grant,
   output logic       ptr_next
);
   assign grant[0] = req_a & (~req_b | (ptr == REQ_A));
   assign grant[1] = req_b & (~req_a | (ptr == REQ_B));
   // the loser of each grant gets priority next time
   assign ptr_next = grant[0] ? REQ_B : grant[1] ? REQ_A : ptr;
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin arbiter and single-transaction sequencer for the 8x8 memory
module mem_access_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int READ_LAT = 1
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_reqA,
   input  logic              i_reqB,
   input  logic              i_weA,
   input  logic              i_weB,
   input  logic [ADDR_W-1:0] i_addrA,
   input  logic [ADDR_W-1:0] i_addrB,
   input  logic [DATA_W-1:0] i_wdataA,
   input  logic [DATA_W-1:0] i_wdataB,
   output logic              o_ackA,
   output logic              o_ackB,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_busy,
   output logic              o_memSelect,
   output logic              o_memOperation,
   output logic [ADDR_W-1:0] o_memAddr,
   output logic [DATA_W-1:0] o_memWdata,
   input  logic [DATA_W-1:0] i_memRdata
);
   localparam int CNT_W = 3;
   state_t state, state_next;
   logic ptr, ptr_next, winner;
   logic [1:0] grant;
   logic [CNT_W-1:0] cnt;
   logic last_wait;
   rr_arbiter2 u_arb (
      .req_a(i_reqA),
      .req_b(i_reqB),
      .ptr(ptr),
      .grant(grant),
      .ptr_next(ptr_next)
   );
   assign last_wait = (state == WAIT) && (cnt == CNT_W'(1));
   always_comb begin
      state_next = state == IDLE  ? (|grant ? ISSUE : IDLE) :
                   state == ISSUE ? (o_memOperation == OP_WRITE ? ACK : WAIT) :
                   state == WAIT  ? (last_wait ? ACK : WAIT) : IDLE;
   end
   // the memory strobes double as the latched transaction registers
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
         ptr <= REQ_A;
         winner <= REQ_A;
         cnt <= '0;
         o_rdata <= '0;
         o_memSelect <= 1'b0;
         o_memOperation <= OP_READ;
         o_memAddr <= '0;
         o_memWdata <= '0;
      end else begin
         state <= state_next;
         o_memSelect <= state_next == ISSUE;
         if (state == IDLE && |grant) begin
            ptr <= ptr_next;
            winner <= grant[1] ? REQ_B : REQ_A;
            o_memOperation <= grant[1] ? i_weB : i_weA;
            o_memAddr <= grant[1] ? i_addrB : i_addrA;
            o_memWdata <= grant[1] ? i_wdataB : i_wdataA;
         end
         if (state == ISSUE) cnt <= CNT_W'(READ_LAT);
         else if (state == WAIT) cnt <= cnt - CNT_W'(1);
         if (last_wait) o_rdata <= i_memRdata;
      end
   end
   assign o_busy = state != IDLE;
   assign o_ackA = (state == ACK) && (winner == REQ_A);
   assign o_ackB = (state == ACK) && (winner == REQ_B);
endmodule
